tag_check: RTL and testbench
============================

# tag_check

Tag store-and-check stage directly downstream of `tag_generation`. It keeps an 8-bit integrity tag per protected word in a small on-chip tag table. A write stores the tag produced for that word; a read compares the freshly generated tag against the stored one and reports match, mismatch or uninitialised. Mismatches drive a saturating violation counter and a sticky alarm for the security monitor.

## Interface
- `TAG_SIZE`, 8: tag width; must equal `tag_generation` `TAG_SIZE`.
- `ADDR_WIDTH`, 6: tag-table index width; table depth = 2**ADDR_WIDTH entries.
- `COUNT_WIDTH`, 16: violation counter width.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state listed under Operation.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store tag, 0 = check tag.
- `req_addr`  in  ADDR_WIDTH  tag-table index.
- `req_tag`  in  TAG_SIZE  tag from `tag_generation` for the word being written or read.
- `resp_valid`  out  1  response present; held until accepted.
- `resp_ready`  in  1  consumer accepts response.
- `resp_status`  out  2  00 OK (write done or tags equal), 01 MISMATCH, 10 UNINIT (read of never-written entry), 11 unused.
- `resp_tag`  out  TAG_SIZE  stored tag read (reads); `req_tag` echoed (writes).
- `violation_count`  out  COUNT_WIDTH  number of MISMATCH responses, saturating.
- `alarm`  out  1  sticky, set by any MISMATCH.
- `alarm_clear`  in  1  clears `alarm`.

## Operation
- FSM states: IDLE, LOOKUP, RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, capture `req_write/req_addr/req_tag`, go to LOOKUP.
- LOOKUP (one cycle): write: table[addr] <= tag, valid[addr] <= 1, status OK. Read: if valid[addr]=0, status UNINIT, resp_tag = stored contents (don't-care); else status OK if stored == captured tag, MISMATCH otherwise. Register status/resp_tag, go to RESP.
- RESP: `resp_valid`=1, `resp_status`/`resp_tag` stable. On `resp_ready`, go to IDLE. Without it, hold indefinitely.
- Counter: increments by 1 in the cycle a MISMATCH enters RESP (once per request, not per stall cycle). It holds at 2**COUNT_WIDTH-1 when saturated.
- Alarm: set in the same cycle the counter would increment. `alarm_clear` drops it next cycle. If a clear and a new MISMATCH occur in the same cycle, the set wins and `alarm` stays 1.
- UNINIT and writes never touch the counter or the alarm.
- Rewriting an entry overwrites the tag and leaves valid=1. There is no invalidate operation; only reset clears valid bits.
- Reset (any state, including mid-request): state goes to IDLE, all valid bits go to 0, `violation_count`=0, `alarm`=0, `resp_valid`=0, `resp_status`=00, `resp_tag`=0. An in-flight request is dropped with no response and no table write if still in IDLE/LOOKUP boundary. Tag contents need not be cleared.
- Requests presented while `reset`=1 are ignored.

## Timing
- Reset values: `req_ready`=1 from the first cycle after `reset` deasserts, `resp_valid`=0, `resp_status`=00, `resp_tag`=0, `violation_count`=0, `alarm`=0.
- Accept in cycle N leads to LOOKUP in N+1 and `resp_valid`=1 in N+2. Fixed latency is 2 cycles when `resp_ready` is high.
- Minimum spacing between accepts is 3 cycles. `req_ready` is 0 in LOOKUP and RESP.
- A write in LOOKUP at cycle N+1 is visible to a read accepted at N+3 or later.
- `violation_count` and `alarm` update at the same edge on which `resp_valid` rises.
- All outputs are registered or depend only on FSM state. There is no combinational path from inputs to outputs.

## Test plan
- Reset then read addr 5, tag 8'h3C -> after 2 cycles `resp_valid`=1, status 10 (UNINIT), count 0, alarm 0.
- Write addr 5 tag 8'h3C, then read addr 5 tag 8'h3C -> write status 00; read status 00, resp_tag 8'h3C, count 0.
- Read addr 5 with tag 8'h3D -> status 01, resp_tag 8'h3C, count 1, alarm 1. Hold `resp_ready`=0 for 4 cycles -> response stable, count stays 1, `req_ready`=0 throughout.
- Assert `alarm_clear` in the same cycle a second MISMATCH enters RESP -> alarm stays 1, count 2. Clear alone next -> alarm 0, count 2.
- COUNT_WIDTH=2: five mismatching reads -> count goes 1, 2, 3, 3, 3.
- Assert reset during LOOKUP of a write to addr 9 -> no response, IDLE next cycle, count 0, alarm 0, subsequent read of addr 5 and addr 9 -> UNINIT.

Source files
------------

// File: rtl/tag_check.sv
// Tag table store/check stage fed by tag_generation.
// Writes record a word's tag; reads compare against it and flag violations.
module tag_check #(
   parameter int TAG_SIZE    = 8,
   parameter int ADDR_WIDTH  = 6,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic [TAG_SIZE-1:0]    req_tag,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [1:0]             resp_status,
   output logic [TAG_SIZE-1:0]    resp_tag,
   output logic [COUNT_WIDTH-1:0] violation_count,
   output logic                   alarm,
   input  logic                   alarm_clear
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [1:0] ST_OK     = 2'b00;
   localparam logic [1:0] ST_MISM   = 2'b01;
   localparam logic [1:0] ST_UNINIT = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOOKUP,
      S_RESP
   } state_e;

   state_e                 state_q, state_d;
   logic                   wr_q, wr_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [TAG_SIZE-1:0]    tag_q, tag_d;
   logic [TAG_SIZE-1:0]    rtag_q, rtag_d;
   logic [1:0]             st_q, st_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   alarm_q, alarm_d;
   logic [DEPTH-1:0]       valid_q, valid_d;
   logic [TAG_SIZE-1:0]    mem_q [DEPTH];
   logic                   mem_we;
   logic [TAG_SIZE-1:0]    stored;

   assign stored = mem_q[addr_q];

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      tag_d   = tag_q;
      rtag_d  = rtag_q;
      st_d    = st_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      mem_we  = 1'b0;
      alarm_d = alarm_clear ? 1'b0 : alarm_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               tag_d   = req_tag;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            state_d = S_RESP;
            rtag_d  = stored;
            if (wr_q) begin
               mem_we          = 1'b1;
               valid_d[addr_q] = 1'b1;
               st_d            = ST_OK;
               rtag_d          = tag_q;
            end else if (!valid_q[addr_q]) begin
               st_d = ST_UNINIT;
            end else if (stored == tag_q) begin
               st_d = ST_OK;
            end else begin
               // A new violation outranks a same-cycle clear.
               st_d    = ST_MISM;
               alarm_d = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         tag_q   <= '0;
         rtag_q  <= '0;
         st_q    <= ST_OK;
         cnt_q   <= '0;
         alarm_q <= 1'b0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         tag_q   <= tag_d;
         rtag_q  <= rtag_d;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
         valid_q <= valid_d;
      end
   end

   // Tag storage is not reset; the valid bits gate its meaning.
   always_ff @(posedge clk) begin
      if (!reset && mem_we) mem_q[addr_q] <= tag_q;
   end

   assign req_ready       = (state_q == S_IDLE);
   assign resp_valid      = (state_q == S_RESP);
   assign resp_status     = st_q;
   assign resp_tag        = rtag_q;
   assign violation_count = cnt_q;
   assign alarm           = alarm_q;

endmodule

// File: tb/tb_tag_check.sv
// Directed bench for tag_check: a table model predicts every cycle's outputs
// for a 16-bit-counter instance and a 2-bit-counter instance driven alike.
module tb_tag_check;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [5:0]  req_addr;
   logic [7:0]  req_tag;
   logic        resp_ready;
   logic        alarm_clear;

   logic        req_ready, req_ready2;
   logic        resp_valid, resp_valid2;
   logic [1:0]  resp_status, resp_status2;
   logic [7:0]  resp_tag, resp_tag2;
   logic [15:0] cnt;
   logic [1:0]  cnt2;
   logic        alarm, alarm2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   tag_check u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_status(resp_status), .resp_tag(resp_tag),
      .violation_count(cnt), .alarm(alarm), .alarm_clear(alarm_clear)
   );

   tag_check #(.COUNT_WIDTH(2)) u_sat (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready2),
      .req_write(req_write), .req_addr(req_addr), .req_tag(req_tag),
      .resp_valid(resp_valid2), .resp_ready(resp_ready),
      .resp_status(resp_status2), .resp_tag(resp_tag2),
      .violation_count(cnt2), .alarm(alarm2), .alarm_clear(alarm_clear)
   );

   // Model: tag table plus expected outputs after the next rising edge.
   logic [7:0] m_tag [64];
   bit         m_val [64];
   int         m_mism;
   logic       e_ready, e_rvalid, e_alarm;
   logic [1:0] e_status;
   logic [7:0] e_tag;
   bit         e_data_chk, e_tag_care;

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      chk("req_ready", req_ready, e_ready);
      chk("req_ready_sat", req_ready2, e_ready);
      chk("resp_valid", resp_valid, e_rvalid);
      chk("resp_valid_sat", resp_valid2, e_rvalid);
      chk("count", cnt, sat(m_mism, 65535));
      chk("count_sat", cnt2, sat(m_mism, 3));
      chk("alarm", alarm, e_alarm);
      chk("alarm_sat", alarm2, e_alarm);
      if (e_data_chk) begin
         chk("status", resp_status, e_status);
         chk("status_sat", resp_status2, e_status);
         if (e_tag_care) begin
            chk("resp_tag", resp_tag, e_tag);
            chk("resp_tag_sat", resp_tag2, e_tag);
         end
      end
   end

   task automatic exp_reset();
      for (int i = 0; i < 64; i++) m_val[i] = 1'b0;
      m_mism     = 0;
      e_ready    = 1'b1;
      e_rvalid   = 1'b0;
      e_alarm    = 1'b0;
      e_status   = 2'b00;
      e_tag      = 8'h00;
      e_data_chk = 1'b1;
      e_tag_care = 1'b1;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b1;
      exp_reset();
      repeat (cycles - 1) @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // lst/ltag/lcnt/lcnt2: literal expectations while in RESP (-1 = skip).
   task automatic req(input bit w, input logic [5:0] a, input logic [7:0] t,
                      input int stall, input bit clr,
                      input int lst, input int ltag,
                      input int lcnt, input int lcnt2);
      bit mism;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_tag    = t;
      e_ready    = 1'b0;
      e_rvalid   = 1'b0;
      e_data_chk = 1'b0;
      @(negedge clk);
      req_valid   = 1'b0;
      alarm_clear = clr;
      mism        = 1'b0;
      e_tag_care  = 1'b1;
      if (w) begin
         m_tag[a] = t;
         m_val[a] = 1'b1;
         e_status = 2'b00;
         e_tag    = t;
      end else if (!m_val[a]) begin
         e_status   = 2'b10;
         e_tag_care = 1'b0;
      end else begin
         e_tag    = m_tag[a];
         mism     = (m_tag[a] != t);
         e_status = mism ? 2'b01 : 2'b00;
      end
      if (mism) begin
         m_mism++;
         e_alarm = 1'b1;
      end else if (clr) begin
         e_alarm = 1'b0;
      end
      e_rvalid   = 1'b1;
      e_data_chk = 1'b1;
      @(negedge clk);
      alarm_clear = 1'b0;
      if (lst >= 0)   chk("lit_status", resp_status, lst);
      if (ltag >= 0)  chk("lit_tag", resp_tag, ltag);
      if (lcnt >= 0)  chk("lit_count", cnt, lcnt);
      if (lcnt2 >= 0) chk("lit_count_sat", cnt2, lcnt2);
      for (int s = 0; s <= stall; s++) begin
         if (s > 0) @(negedge clk);
         resp_ready = (s == stall);
         if (s == stall) begin
            e_rvalid   = 1'b0;
            e_ready    = 1'b1;
            e_data_chk = 1'b0;
         end
      end
   endtask

   task automatic clear_alarm();
      @(negedge clk);
      alarm_clear = 1'b1;
      e_alarm     = 1'b0;
      @(negedge clk);
      alarm_clear = 1'b0;
      chk("lit_alarm_cleared", alarm, 1'b0);
      chk("lit_count_kept", cnt, 2);
   endtask

   task automatic reset_in_lookup(input logic [5:0] a, input logic [7:0] t);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = a;
      req_tag    = t;
      e_ready    = 1'b0;
      e_rvalid   = 1'b0;
      e_data_chk = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      reset     = 1'b1;
      exp_reset();
      @(negedge clk);
      reset = 1'b0;
      chk("lit_ready_after_rst", req_ready, 1'b1);
   endtask

   initial begin
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_write   = 1'b0;
      req_addr    = '0;
      req_tag     = '0;
      resp_ready  = 1'b1;
      alarm_clear = 1'b0;
      exp_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      req(0, 6'd5, 8'h3C, 0, 0, 2, -1, 0, 0);
      req(1, 6'd5, 8'h3C, 0, 0, 0, 'h3C, 0, 0);
      req(0, 6'd5, 8'h3C, 0, 0, 0, 'h3C, 0, 0);
      req(0, 6'd5, 8'h3D, 4, 0, 1, 'h3C, 1, 1);
      req(0, 6'd5, 8'h3E, 0, 1, 1, 'h3C, 2, 2);
      clear_alarm();
      req(0, 6'd5, 8'h00, 0, 0, 1, 'h3C, 3, 3);
      req(0, 6'd5, 8'h11, 0, 0, 1, 'h3C, 4, 3);
      req(0, 6'd5, 8'h22, 2, 0, 1, 'h3C, 5, 3);
      req(1, 6'd63, 8'hAA, 0, 0, 0, 'hAA, -1, -1);
      req(1, 6'd0, 8'h55, 0, 0, 0, 'h55, -1, -1);
      req(0, 6'd63, 8'hAA, 0, 0, 0, 'hAA, 5, 3);
      req(0, 6'd0, 8'h54, 1, 0, 1, 'h55, 6, 3);
      req(1, 6'd0, 8'h54, 0, 0, 0, 'h54, -1, -1);
      req(0, 6'd0, 8'h54, 0, 0, 0, 'h54, 6, 3);

      reset_in_lookup(6'd9, 8'h77);
      req(0, 6'd5, 8'h3C, 0, 0, 2, -1, 0, 0);
      req(0, 6'd9, 8'h77, 0, 0, 2, -1, 0, 0);
      req(1, 6'd9, 8'h77, 0, 0, 0, 'h77, 0, 0);
      req(0, 6'd9, 8'h78, 0, 0, 1, 'h77, 1, 1);
      do_reset(2);
      req(0, 6'd9, 8'h77, 0, 0, 2, -1, 0, 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
